bus_rr_arbiter: RTL and testbench

Central round-robin controller for the shared router bus. It picks one terminal with a pending packet, pops that packet from the terminal's output FIFO, and decodes the 8-bit destination ID in the packet's top byte. It then pushes the packet into the destination terminal's input FIFO, or into every other terminal's input FIFO for broadcast. It sits between the per-terminal FIFOs of the bus generator and is the single owner of the bus data path.

---
 rtl/bus_rr_arbiter.sv | 170 +++++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus controller for the shared router bus.
// Picks one terminal with a pending packet, pops its head word, decodes the destination
// byte in the packet's top bits, then pushes the packet to one terminal input FIFO or,
// for broadcast, to every terminal except the source.
//
// Ports:
//   clk_i       rising-edge clock
//   reset_ni    synchronous active-low reset
//   pndng_i     per-terminal "output FIFO non-empty"
//   data_in_i   per-terminal head word (first-word fall-through), terminal i at [i*W +: W]
//   full_i      per-terminal "input FIFO full"
//   pop_o       one-hot pop strobe to the source FIFO
//   push_o      push strobe(s) to destination FIFO(s)
//   data_out_o  bus word, zero unless push_o != 0
//   grant_id_o  current / last granted terminal
//   busy_o      high whenever not idle
//   pkt_cnt_o   delivered packets (wrapping)
//   drop_cnt_o  packets dropped for an invalid destination (wrapping)
module bus_rr_arbiter #(
    parameter int unsigned num_ntrfs = 4,
    parameter int unsigned pckg_sz   = 32,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                           clk_i,
    input  logic                           reset_ni,
    input  logic [num_ntrfs-1:0]           pndng_i,
    input  logic [num_ntrfs*pckg_sz-1:0]   data_in_i,
    input  logic [num_ntrfs-1:0]           full_i,
    output logic [num_ntrfs-1:0]           pop_o,
    output logic [num_ntrfs-1:0]           push_o,
    output logic [pckg_sz-1:0]             data_out_o,
    output logic [3:0]                     grant_id_o,
    output logic                           busy_o,
    output logic [15:0]                    pkt_cnt_o,
    output logic [15:0]                    drop_cnt_o
);

    typedef logic [num_ntrfs-1:0] ntrf_t;
    typedef enum logic [1:0] {StIdle, StPop, StRoute, StPush} state_e;

    state_e             state_q, state_d;
    logic [3:0]         grant_q, grant_d;
    logic [pckg_sz-1:0] pkt_q, pkt_d;
    logic [15:0]        pkt_cnt_q, pkt_cnt_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;

    logic               any_pndng;
    logic               arb_found;
    logic [3:0]         winner;
    logic [pckg_sz-1:0] head_word;
    logic [7:0]         dest;
    ntrf_t              grant_oh;
    ntrf_t              mask;
    logic               dest_ok;

    assign any_pndng = |pndng_i;
    assign grant_oh  = ntrf_t'(1) << grant_q;

    // Winner is the first pending terminal after grant_q, wrapping around.
    always_comb begin : arbitrate
        winner    = grant_q;
        arb_found = 1'b0;
        for (int unsigned k = 1; k <= num_ntrfs; k++) begin
            for (int unsigned j = 0; j < num_ntrfs; j++) begin
                if (!arb_found && pndng_i[j] && ((32'(grant_q) + k) % num_ntrfs) == j) begin
                    winner    = 4'(j);
                    arb_found = 1'b1;
                end
            end
        end
    end

    always_comb begin : head_mux
        head_word = '0;
        for (int unsigned j = 0; j < num_ntrfs; j++) begin
            if (grant_q == 4'(j)) begin
                head_word = data_in_i[j*pckg_sz +: pckg_sz];
            end
        end
    end

    // Target mask from the captured packet; stays stable through ROUTE and PUSH.
    always_comb begin : route_decode
        dest    = pkt_q[pckg_sz-1 -: 8];
        mask    = '0;
        dest_ok = 1'b0;
        if (dest == broadcast) begin
            mask    = ~grant_oh;
            dest_ok = 1'b1;
        end else if (32'(dest) < num_ntrfs) begin
            mask    = ntrf_t'(1) << dest;
            dest_ok = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin : state_reg
        if (!reset_ni) begin
            state_q    <= StIdle;
            grant_q    <= 4'(num_ntrfs - 1);
            pkt_q      <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            pkt_q      <= pkt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin : next_state
        state_d    = state_q;
        grant_d    = grant_q;
        pkt_d      = pkt_q;
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (any_pndng) begin
                    grant_d = winner;
                    state_d = StPop;
                end
            end
            StPop: begin
                pkt_d   = head_word;
                state_d = StRoute;
            end
            StRoute: begin
                if (!dest_ok) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                    state_d    = StIdle;
                end else if ((mask & full_i) == '0) begin
                    // Deliver only when every target can accept; no partial broadcast.
                    state_d = StPush;
                end
            end
            StPush: begin
                pkt_cnt_d = pkt_cnt_q + 16'd1;
                if (any_pndng) begin
                    grant_d = winner;
                    state_d = StPop;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin : outputs
        pop_o      = '0;
        push_o     = '0;
        data_out_o = '0;
        busy_o     = (state_q != StIdle);
        unique case (state_q)
            StPop:  pop_o = grant_oh;
            StPush: begin
                push_o     = mask;
                data_out_o = pkt_q;
            end
            default: ;
        endcase
    end

    assign grant_id_o = grant_q;
    assign pkt_cnt_o  = pkt_cnt_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter (4 terminals, 32-bit packets).
// A transaction-stage model predicts every output each cycle; directed literal checks
// pin the model against hand-computed values.
module tb_bus_rr_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   pndng;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   full;
    logic [N-1:0]   pop;
    logic [N-1:0]   push;
    logic [W-1:0]   data_out;
    logic [3:0]     grant_id;
    logic           busy;
    logic [15:0]    pkt_cnt;
    logic [15:0]    drop_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    bus_rr_arbiter #(
        .num_ntrfs (N),
        .pckg_sz   (W),
        .broadcast (8'hFF)
    ) dut (
        .clk_i      (clk),
        .reset_ni   (reset_n),
        .pndng_i    (pndng),
        .data_in_i  (data_in),
        .full_i     (full),
        .pop_o      (pop),
        .push_o     (push),
        .data_out_o (data_out),
        .grant_id_o (grant_id),
        .busy_o     (busy),
        .pkt_cnt_o  (pkt_cnt),
        .drop_cnt_o (drop_cnt)
    );

    always #5 clk = ~clk;

    // Model: a packet in flight has a stage: 0 = being popped, 1 = awaiting targets,
    // 2 = being delivered.
    bit          m_active  = 1'b0;
    int          m_stage   = 0;
    int          m_src     = 0;
    int          m_last    = N - 1;
    logic [W-1:0] m_word   = '0;
    logic [N-1:0] m_targets = '0;
    logic [15:0] m_pkts    = '0;
    logic [15:0] m_drops   = '0;

    always @(posedge clk) begin : model
        bit start_new;
        int dest;
        bit found;
        if (!reset_n) begin
            m_active = 1'b0;
            m_last   = N - 1;
            m_pkts   = '0;
            m_drops  = '0;
        end else begin
            start_new = !m_active;
            if (m_active) begin
                if (m_stage == 0) begin
                    m_word  = data_in[m_src*W +: W];
                    m_stage = 1;
                end else if (m_stage == 1) begin
                    dest = int'(m_word[W-1:W-8]);
                    if (dest == 255)   m_targets = ((N)'(2**N - 1)) ^ ((N)'(1) << m_src);
                    else if (dest < N) m_targets = (N)'(1) << dest;
                    else               m_targets = '0;
                    if (m_targets == '0) begin
                        m_drops  = m_drops + 16'd1;
                        m_active = 1'b0;
                    end else if ((m_targets & full) == '0) begin
                        m_stage = 2;
                    end
                end else begin
                    m_pkts    = m_pkts + 16'd1;
                    start_new = 1'b1;
                end
            end
            if (start_new) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    if (!found && pndng[(m_last + k) % N]) begin
                        found = 1'b1;
                        m_src = (m_last + k) % N;
                    end
                end
                m_active = found;
                if (found) begin
                    m_stage = 0;
                    m_last  = m_src;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h, want %h", name, act, exp);
        else n_pass++;
    endtask

    // Advance to the next falling edge and compare every output with the model.
    task automatic tick();
        logic [76:0] got;
        logic [76:0] want;
        logic [N-1:0] e_pop;
        logic [N-1:0] e_push;
        @(negedge clk);
        e_pop  = (m_active && m_stage == 0) ? (N)'(1) << m_src : '0;
        e_push = (m_active && m_stage == 2) ? m_targets : '0;
        want = {e_pop, e_push, (e_push != '0) ? m_word : 32'h0, m_active, 4'(m_last),
                m_pkts, m_drops};
        got  = {pop, push, data_out, busy, grant_id, pkt_cnt, drop_cnt};
        n_checks++;
        if (got !== want) $display("FAIL cycle@%0t: got %h, want %h", $time, got, want);
        else n_pass++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    // Offer one packet from src; returns at the falling edge of the first ROUTE cycle.
    task automatic issue(input int src, input logic [W-1:0] word);
        data_in[src*W +: W] = word;
        pndng = (N)'(1) << src;
        tick();
        check("pop", 32'(pop), 32'(1 << src));
        pndng = '0;
        tick();
    endtask

    int g_seq[5];
    int c_seq[5];
    int n_pops;
    int cyc;
    bit drained;

    initial begin
        reset_n = 1'b0;
        pndng   = '0;
        full    = '0;
        data_in = '0;
        tick();
        tick();
        reset_n = 1'b1;

        // Idle after reset
        repeat (20) tick();
        check("idle_pop", 32'(pop), 32'h0);
        check("idle_push", 32'(push), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_grant", 32'(grant_id), 32'd3);
        check("idle_cnts", {pkt_cnt, drop_cnt}, 32'h0);

        // Single unicast 2 -> 1
        issue(2, 32'h0100ABCD);
        tick();
        check("uni_push", 32'(push), 32'b0010);
        check("uni_data", data_out, 32'h0100ABCD);
        tick();
        check("uni_cnt", 32'(pkt_cnt), 32'd1);
        check("uni_push_off", 32'(push), 32'h0);
        check("uni_data_off", data_out, 32'h0);

        // Round-robin under continuous load
        do_reset();
        check("rst_grant", 32'(grant_id), 32'd3);
        for (int i = 0; i < N; i++) data_in[i*W +: W] = {8'(i), 24'hC0DE00 | 24'(i)};
        pndng  = 4'b1111;
        n_pops = 0;
        cyc    = 0;
        while (n_pops < 5 && cyc < 20) begin
            tick();
            cyc++;
            if (pop != '0) begin
                g_seq[n_pops] = int'(grant_id);
                c_seq[n_pops] = cyc;
                n_pops++;
            end
        end
        pndng = '0;
        check("rr_npops", 32'(n_pops), 32'd5);
        for (int i = 0; i < n_pops; i++) begin
            check("rr_grant", 32'(g_seq[i]), 32'(i % N));
            if (i > 0) check("rr_spacing", 32'(c_seq[i] - c_seq[i-1]), 32'd3);
        end
        drained = 1'b0;
        for (int i = 0; i < 10 && !drained; i++) begin
            tick();
            drained = !busy;
        end
        check("rr_drain", 32'(drained), 32'd1);
        check("rr_cnt", 32'(pkt_cnt), 32'd5);

        // Broadcast from terminal 1
        issue(1, 32'hFF000001);
        tick();
        check("bc_push", 32'(push), 32'b1101);
        check("bc_data", data_out, 32'hFF000001);
        tick();
        check("bc_push_off", 32'(push), 32'h0);

        // Invalid destination is dropped
        issue(0, 32'h07000000);
        tick();
        check("drop_cnt", 32'(drop_cnt), 32'd1);
        check("drop_busy", 32'(busy), 32'h0);
        check("drop_push", 32'(push), 32'h0);

        // Stall on a full target, then release
        full = 4'b1000;
        issue(0, 32'h03000055);
        for (int i = 0; i < 5; i++) begin
            check("stall_push", 32'(push), 32'h0);
            check("stall_busy", 32'(busy), 32'd1);
            tick();
        end
        full = '0;
        tick();
        check("stall_release", 32'(push), 32'b1000);
        check("stall_data", data_out, 32'h03000055);
        tick();
        check("stall_cnt", 32'(pkt_cnt), 32'd7);

        // Reset while stalled discards the packet
        full = 4'b1000;
        issue(0, 32'h03000055);
        tick();
        check("pre_rst_cnt", 32'(pkt_cnt), 32'd7);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        full    = '0;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cnt", 32'(pkt_cnt), 32'h0);
        check("rst_grant2", 32'(grant_id), 32'd3);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_no_push", 32'(push), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

endmodule
